// File: rtl/pcb_write_arbiter.sv
// pcb_write_arbiter: round-robin arbiter that shares the single PCB RAM write
// port among NUM_PORT input-buffer requesters. The winner's word and address
// are registered onto the RAM port, and a one-cycle ack goes back to the winner
// in the same cycle.
// Optional feature: define PKT_LOCK_EN for packet-level grants. A granted head
// word locks the arbiter to that port until the port's tail word is granted.
module pcb_write_arbiter #(
  parameter int NUM_PORT = 8,
  parameter int DATA_W   = 134,
  parameter int PTR_W    = 3
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [NUM_PORT-1:0]        iv_pkt_wr,
  input  logic [NUM_PORT*DATA_W-1:0] iv_pkt,
  input  logic [NUM_PORT*16-1:0]     iv_pkt_bufadd,
  output logic [NUM_PORT-1:0]        ov_pkt_ack,
  input  logic                       i_ram_rdy,
  output logic                       o_ram_wr,
  output logic [DATA_W-1:0]          ov_ram_wdata,
  output logic [15:0]                ov_ram_addr,
  output logic [PTR_W-1:0]           ov_grant_port
);

  typedef enum logic {IDLE_S, LOCK_S} state_t;

`ifdef PKT_LOCK_EN
  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_TAIL = 2'b10;
`endif

  state_t              state;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    lock_port;

  logic [NUM_PORT-1:0] elig_p0;
  logic                vld_p0;
  logic [PTR_W-1:0]    win_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [15:0]         addr_p0;

  logic                vld_p1;
  logic [NUM_PORT-1:0] ack_p1;
  logic [DATA_W-1:0]   wdata_p1;
  logic [15:0]         addr_p1;
  logic [PTR_W-1:0]    grant_p1;

  // First set bit of req, scanning upward from start and wrapping to port 0.
  // The loop runs downward so that the last hit it keeps is the closest one
  // to start.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_PORT-1:0] req,
                                               input logic [PTR_W-1:0]    start);
    logic [PTR_W-1:0] pick;
    int               idx;
    pick = start;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      if (req[idx]) pick = PTR_W'(idx);
    end
    return pick;
  endfunction

  // Round-robin successor. This also covers a NUM_PORT that is not a power of two.
  function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_PORT - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---- stage p0: eligibility and winner selection (combinational) ----
  // A port that is being acked this cycle still holds its request high. It is
  // masked out so that the same word is not granted twice. When locked, only
  // the lock owner may win.
  always_comb begin
    elig_p0 = iv_pkt_wr & ~ack_p1;
    if (state == LOCK_S) elig_p0 = elig_p0 & (NUM_PORT'(1) << lock_port);
    vld_p0   = i_ram_rdy & (|elig_p0);
    win_p0   = rr_pick(elig_p0, rr_ptr);
    wdata_p0 = iv_pkt[win_p0*DATA_W +: DATA_W];
    addr_p0  = iv_pkt_bufadd[win_p0*16 +: 16];
  end

  // ---- stage p1: registered RAM write, ack, pointer and lock FSM ----
  // Reset clears everything immediately, which drops any grant in flight.
  // On a cycle with no grant, the data and address hold their last values.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state     <= IDLE_S;
      rr_ptr    <= '0;
      lock_port <= '0;
      vld_p1    <= 1'b0;
      ack_p1    <= '0;
      wdata_p1  <= '0;
      addr_p1   <= '0;
      grant_p1  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      ack_p1 <= '0;
      if (vld_p0) begin
        ack_p1   <= NUM_PORT'(1) << win_p0;
        wdata_p1 <= wdata_p0;
        addr_p1  <= addr_p0;
        grant_p1 <= win_p0;
        rr_ptr   <= next_port(win_p0);
`ifdef PKT_LOCK_EN
        case (state)
          IDLE_S: begin
            if (wdata_p0[DATA_W-1 -: 2] == HDR_HEAD) begin
              lock_port <= win_p0;
              state     <= LOCK_S;
            end
          end
          LOCK_S: begin
            if (wdata_p0[DATA_W-1 -: 2] == HDR_TAIL) state <= IDLE_S;
          end
          default: state <= IDLE_S;
        endcase
`endif
      end
    end
  end

  assign o_ram_wr      = vld_p1;
  assign ov_pkt_ack    = ack_p1;
  assign ov_ram_wdata  = wdata_p1;
  assign ov_ram_addr   = addr_p1;
  assign ov_grant_port = grant_p1;

endmodule

// File: tb/tb_pcb_write_arbiter.sv
// Testbench for pcb_write_arbiter. Per-port word queues act as the input
// buffers. A queue/arithmetic reference model predicts every output cycle.
module tb_pcb_write_arbiter;
  localparam int NP = 8;
  localparam int DW = 134;
  localparam int PW = 3;

  logic               clk_sys = 1'b0;
  logic               reset = 1'b1;
  logic [NP-1:0]      iv_pkt_wr = '0;
  logic [NP*DW-1:0]   iv_pkt = '0;
  logic [NP*16-1:0]   iv_pkt_bufadd = '0;
  logic [NP-1:0]      ov_pkt_ack;
  logic               i_ram_rdy = 1'b0;
  logic               o_ram_wr;
  logic [DW-1:0]      ov_ram_wdata;
  logic [15:0]        ov_ram_addr;
  logic [PW-1:0]      ov_grant_port;

  pcb_write_arbiter #(.NUM_PORT(NP), .DATA_W(DW), .PTR_W(PW)) dut (
    .clk_sys(clk_sys), .reset(reset), .iv_pkt_wr(iv_pkt_wr), .iv_pkt(iv_pkt),
    .iv_pkt_bufadd(iv_pkt_bufadd), .ov_pkt_ack(ov_pkt_ack), .i_ram_rdy(i_ram_rdy),
    .o_ram_wr(o_ram_wr), .ov_ram_wdata(ov_ram_wdata), .ov_ram_addr(ov_ram_addr),
    .ov_grant_port(ov_grant_port)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q_word [NP][$];
  logic [15:0]   q_addr [NP][$];

  // reference model state
  int            m_rr;
  int            m_lock;
  bit            m_locked;
  logic          m_wr;
  logic [NP-1:0] m_ack;
  logic [DW-1:0] m_data;
  logic [15:0]   m_addr;
  logic [PW-1:0] m_grant;

  function automatic logic [DW-1:0] mk_word(input logic [1:0] hdr);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = 1'($urandom_range(0, 1));
    w[DW-1 -: 2] = hdr;
    return w;
  endfunction

  task automatic push(input int p, input logic [1:0] hdr, input logic [15:0] a);
    q_word[p].push_back(mk_word(hdr));
    q_addr[p].push_back(a);
  endtask

  // one well-formed packet: single word, or head + 0..3 bodies + tail
  task automatic push_pkt(input int p);
    int nb;
    if ($urandom_range(0, 2) == 0) begin
      push(p, 2'b11, 16'($urandom));
    end else begin
      nb = $urandom_range(0, 3);
      push(p, 2'b01, 16'($urandom));
      for (int i = 0; i < nb; i++) push(p, 2'b00, 16'($urandom));
      push(p, 2'b10, 16'($urandom));
    end
  endtask

  task automatic clear_queues;
    for (int p = 0; p < NP; p++) begin
      q_word[p].delete();
      q_addr[p].delete();
    end
  endtask

  task automatic model_reset;
    m_rr = 0; m_lock = 0; m_locked = 0;
    m_wr = 1'b0; m_ack = '0; m_data = '0; m_addr = '0; m_grant = '0;
  endtask

  task automatic do_reset;
    @(negedge clk_sys);
    reset = 1'b1;
    iv_pkt_wr = '0;
    i_ram_rdy = 1'b0;
    clear_queues();
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // Drive one cycle of requests from the queue fronts, predict the result,
  // then advance to just after the clock edge.
  task automatic step(input logic rdy);
    logic [NP-1:0] elig;
    int            win;
    int            idx;
    @(negedge clk_sys);
    i_ram_rdy = rdy;
    for (int p = 0; p < NP; p++) begin
      if (q_word[p].size() > 0) begin
        iv_pkt_wr[p]              = 1'b1;
        iv_pkt[p*DW +: DW]        = q_word[p][0];
        iv_pkt_bufadd[p*16 +: 16] = q_addr[p][0];
      end else begin
        iv_pkt_wr[p] = 1'b0;
      end
    end
    elig = iv_pkt_wr & ~m_ack;
    if (m_locked) elig = elig & (NP'(1) << m_lock);
    win = -1;
    if (rdy) begin
      for (int k = 0; k < NP; k++) begin
        idx = (m_rr + k) % NP;
        if (elig[idx]) begin
          win = idx;
          break;
        end
      end
    end
    if (win >= 0) begin
      m_wr    = 1'b1;
      m_ack   = NP'(1) << win;
      m_data  = q_word[win].pop_front();
      m_addr  = q_addr[win].pop_front();
      m_grant = PW'(win);
      m_rr    = (win + 1) % NP;
`ifdef PKT_LOCK_EN
      if (!m_locked && m_data[DW-1 -: 2] == 2'b01) begin
        m_locked = 1'b1;
        m_lock   = win;
      end else if (m_locked && m_data[DW-1 -: 2] == 2'b10) begin
        m_locked = 1'b0;
      end
`endif
    end else begin
      m_wr  = 1'b0;
      m_ack = '0;
    end
    @(posedge clk_sys);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got wr=%b ack=%h grant=%0d addr=%h, want all zero",
               o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr);
    end
    do_reset();
  endtask

  task automatic test_single_port2;
    do_reset();
    push(2, 2'b01, 16'h0100);
    push(2, 2'b10, 16'h0101);
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr} !== {1'b1, 8'h04, 3'd2, 16'h0100}) begin
      n_err++;
      $display("FAIL port2_grant: got wr=%b ack=%h grant=%0d addr=%h, want wr=1 ack=04 grant=2 addr=0100",
               o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr);
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b1);
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !==
          {m_wr, m_ack, m_grant, m_addr, m_data}) begin
        n_err++;
        $display("FAIL port2_model c%0d: got wr=%b ack=%h grant=%0d addr=%h, want wr=%b ack=%h grant=%0d addr=%h",
                 c, o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, m_wr, m_ack, m_grant, m_addr);
      end
    end
    push(1, 2'b11, 16'h0111);
    push(4, 2'b11, 16'h0444);
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_grant_port, ov_ram_addr} !== {1'b1, 3'd4, 16'h0444}) begin
      n_err++;
      $display("FAIL ptr_after_port2: got wr=%b grant=%0d addr=%h, want wr=1 grant=4 addr=0444",
               o_ram_wr, ov_grant_port, ov_ram_addr);
    end
  endtask

  task automatic test_round_robin;
    int exp_seq [3] = '{0, 3, 7};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 2'b11, 16'(16'h0A00 + i));
      push(3, 2'b11, 16'(16'h0A30 + i));
      push(7, 2'b11, 16'(16'h0A70 + i));
    end
    for (int c = 0; c < 9; c++) begin
      step(1'b1);
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !==
          {1'b1, NP'(1) << exp_seq[c % 3], PW'(exp_seq[c % 3]), m_addr, m_data}) begin
        n_err++;
        $display("FAIL rr_037 c%0d: got wr=%b ack=%h grant=%0d addr=%h, want wr=1 grant=%0d addr=%h",
                 c, o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, exp_seq[c % 3], m_addr);
      end
    end
  endtask

  task automatic test_single_port5;
    do_reset();
    for (int i = 0; i < 6; i++) push(5, 2'b11, 16'(16'h0500 + i));
    for (int c = 0; c < 12; c++) begin
      step(1'b1);
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack} !== ((c % 2 == 0) ? {1'b1, 8'h20} : {1'b0, 8'h00})) begin
        n_err++;
        $display("FAIL port5_alternate c%0d: got wr=%b ack=%h, want ack on even cycles only",
                 c, o_ram_wr, ov_pkt_ack);
      end
    end
  endtask

  task automatic test_rdy_stall;
    logic [DW-1:0] held;
    do_reset();
    push(3, 2'b11, 16'h0333);
    step(1'b1);
    held = m_data;
    push(1, 2'b11, 16'h0111);
    push(4, 2'b11, 16'h0444);
    for (int c = 0; c < 4; c++) begin
      step(1'b0);
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack, ov_ram_addr, ov_ram_wdata} !== {1'b0, 8'h00, 16'h0333, held}) begin
        n_err++;
        $display("FAIL rdy_stall c%0d: got wr=%b ack=%h addr=%h, want wr=0 ack=00 addr=0333 (held)",
                 c, o_ram_wr, ov_pkt_ack, ov_ram_addr);
      end
    end
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack, ov_ram_addr} !== {1'b1, 8'h10, 16'h0444}) begin
      n_err++;
      $display("FAIL rdy_resume_first: got wr=%b ack=%h addr=%h, want wr=1 ack=10 addr=0444",
               o_ram_wr, ov_pkt_ack, ov_ram_addr);
    end
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack, ov_ram_addr} !== {1'b1, 8'h02, 16'h0111}) begin
      n_err++;
      $display("FAIL rdy_resume_second: got wr=%b ack=%h addr=%h, want wr=1 ack=02 addr=0111",
               o_ram_wr, ov_pkt_ack, ov_ram_addr);
    end
  endtask

  task automatic test_lock;
    int order [6];
    int n_got;
`ifdef PKT_LOCK_EN
    int exp_order [6] = '{1, 1, 1, 1, 6, 6};
`else
    int exp_order [6] = '{1, 6, 1, 6, 1, 6};
`endif
    do_reset();
    push(1, 2'b01, 16'h0010);
    push(1, 2'b00, 16'h0011);
    push(1, 2'b00, 16'h0012);
    push(1, 2'b10, 16'h0013);
    for (int i = 0; i < 6; i++) push(6, 2'b11, 16'(16'h0060 + i));
    n_got = 0;
    for (int c = 0; c < 30 && n_got < 6; c++) begin
      step(1'b1);
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !==
          {m_wr, m_ack, m_grant, m_addr, m_data}) begin
        n_err++;
        $display("FAIL lock_model c%0d: got wr=%b ack=%h grant=%0d addr=%h, want wr=%b ack=%h grant=%0d addr=%h",
                 c, o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, m_wr, m_ack, m_grant, m_addr);
      end
      if (o_ram_wr === 1'b1) begin
        order[n_got] = int'(ov_grant_port);
        n_got++;
      end
    end
    n_cmp++;
    if (n_got < 6) begin
      n_err++;
      $display("FAIL lock_order_timeout: got %0d writes, want 6", n_got);
    end else if (order != exp_order) begin
      n_err++;
      $display("FAIL lock_order: got %0d %0d %0d %0d %0d %0d, want %0d %0d %0d %0d %0d %0d",
               order[0], order[1], order[2], order[3], order[4], order[5],
               exp_order[0], exp_order[1], exp_order[2], exp_order[3], exp_order[4], exp_order[5]);
    end
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    push(3, 2'b01, 16'h0300);
    push(3, 2'b00, 16'h0301);
    push(3, 2'b10, 16'h0302);
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack} !== {1'b1, 8'h08}) begin
      n_err++;
      $display("FAIL mid_pre_grant: got wr=%b ack=%h, want wr=1 ack=08", o_ram_wr, ov_pkt_ack);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_async: got wr=%b ack=%h grant=%0d addr=%h, want all zero",
               o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr);
    end
    iv_pkt_wr = '0;
    clear_queues();
    model_reset();
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
    push(1, 2'b11, 16'h0101);
    push(6, 2'b11, 16'h0606);
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_grant_port, ov_ram_addr} !== {1'b1, 3'd1, 16'h0101}) begin
      n_err++;
      $display("FAIL mid_ptr_zero: got wr=%b grant=%0d addr=%h, want wr=1 grant=1 addr=0101",
               o_ram_wr, ov_grant_port, ov_ram_addr);
    end
    step(1'b1);
    n_cmp++;
    if ({o_ram_wr, ov_grant_port, ov_ram_addr} !== {1'b1, 3'd6, 16'h0606}) begin
      n_err++;
      $display("FAIL mid_unlocked: got wr=%b grant=%0d addr=%h, want wr=1 grant=6 addr=0606",
               o_ram_wr, ov_grant_port, ov_ram_addr);
    end
  endtask

  task automatic test_random;
    do_reset();
    for (int p = 0; p < NP; p++) if ($urandom_range(0, 1) == 1) push_pkt(p);
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) push_pkt($urandom_range(0, NP - 1));
      step(1'($urandom_range(0, 3) != 0));
      n_cmp++;
      if ({o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, ov_ram_wdata} !==
          {m_wr, m_ack, m_grant, m_addr, m_data}) begin
        n_err++;
        $display("FAIL random c%0d: got wr=%b ack=%h grant=%0d addr=%h, want wr=%b ack=%h grant=%0d addr=%h",
                 c, o_ram_wr, ov_pkt_ack, ov_grant_port, ov_ram_addr, m_wr, m_ack, m_grant, m_addr);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_port2();
    test_round_robin();
    test_single_port5();
    test_rdy_stall();
    test_lock();
    test_reset_mid_grant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
